// File: rtl/seg_display_scanner_pkg.sv
// Shared types and constants for the 7-segment scanner: FSM encoding and
// active-low segment patterns ordered {g,f,e,d,c,b,a}.
package seg_display_scanner_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed by nibble value; entries 10..15 are the hex letters A b C d E F.
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_display_scanner_decoder.sv
// Combinational nibble to active-low 7-segment decoder; non-decimal nibbles
// show hex letters or stay dark depending on HEX_MODE.
module seg_decoder
  import seg_display_scanner_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    if (HEX_MODE == 0 && nibble > 4'd9) segments = SEG_BLANK;
    else                                segments = SEG_PATTERN[nibble];
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Scans NUM_DIGITS common-anode digits, stepping on each seg_clock rising edge,
// with a per-frame snapshot, anti-ghosting guard gap and leading-zero blanking.
//
//  state | meaning
//  OFF   | after reset, all dark, waiting for the first scan tick
//  GUARD | all anodes off for BLANK_CYCLES cycles after a digit switch
//  SHOW  | one anode low, segments from the snapshot digit at index
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int HEX_MODE     = 1
) (
  input  logic                    fast_clock,
  input  logic                    rst,
  input  logic                    seg_clock,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lead,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    scan_tick
);

  localparam int              IW         = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]      GUARD_LOAD = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);

  logic                    s1, s2;
  state_t                  state, state_n;
  logic [IW-1:0]           index, index_n, index_inc;
  logic [7:0]              guard_cnt, guard_n;
  logic [4*NUM_DIGITS-1:0] snap_value, snap_value_n;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_n;
  logic                    snap_blank, snap_blank_n;
  logic                    wrap, load;
  logic [3:0]              digit_nib;
  logic [6:0]              dec_seg;
  logic                    lead_blank, all_zero;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;

  assign wrap      = (index == LAST_IDX);
  assign index_inc = wrap ? '0 : index + 1'b1;

  always_comb begin
    state_n      = state;
    index_n      = index;
    guard_n      = guard_cnt;
    load         = 1'b0;
    case (state)
      ST_OFF, ST_SHOW: begin
        if (scan_tick) begin
          index_n = (state == ST_OFF) ? '0 : index_inc;
          load    = (state == ST_OFF) || wrap;
          if (BLANK_CYCLES == 0) begin
            state_n = ST_SHOW;
          end else begin
            state_n = ST_GUARD;
            guard_n = GUARD_LOAD;
          end
        end
      end
      ST_GUARD: begin
        // A tick arriving before the gap ends restarts the gap on the next digit.
        if (scan_tick) begin
          index_n = index_inc;
          load    = wrap;
          guard_n = GUARD_LOAD;
        end else if (guard_cnt == 8'd0) begin
          state_n = ST_SHOW;
        end else begin
          guard_n = guard_cnt - 8'd1;
        end
      end
      default: state_n = ST_OFF;
    endcase
    snap_value_n = load ? value      : snap_value;
    snap_dp_n    = load ? dp_mask    : snap_dp;
    snap_blank_n = load ? blank_lead : snap_blank;
  end

  // Outputs are decoded from next-cycle state so they change on the entering edge.
  assign digit_nib = snap_value_n[{index_n, 2'b00} +: 4];

  seg_decoder #(.HEX_MODE(HEX_MODE)) u_decoder (
    .nibble   (digit_nib),
    .segments (dec_seg)
  );

  always_comb begin
    lead_blank = 1'b0;
    all_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (snap_value_n[4*i +: 4] == 4'd0);
      if (i == int'(index_n)) lead_blank = snap_blank_n & all_zero;
    end
  end

  always_comb begin
    an_n  = '1;
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    if (state_n == ST_SHOW) begin
      an_n[index_n] = 1'b0;
      seg_n         = lead_blank ? SEG_BLANK : dec_seg;
      dp_n          = ~snap_dp_n[index_n];
    end
  end

  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      scan_tick  <= 1'b0;
      state      <= ST_OFF;
      index      <= '0;
      guard_cnt  <= 8'd0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      s1         <= seg_clock;
      s2         <= s1;
      scan_tick  <= s1 & ~s2;
      state      <= state_n;
      index      <= index_n;
      guard_cnt  <= guard_n;
      snap_value <= snap_value_n;
      snap_dp    <= snap_dp_n;
      snap_blank <= snap_blank_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner (4 digits, 2 guard cycles, hex mode):
// vector table of digit steps plus hand-written burst and reset sequences.
module tb_seg_display_scanner;

  logic        fast_clock = 1'b0;
  logic        rst;
  logic        seg_clock;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        blank_lead;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  int checks = 0;
  int errors = 0;

  seg_display_scanner #(
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2),
    .HEX_MODE     (1)
  ) dut (
    .fast_clock (fast_clock),
    .rst        (rst),
    .seg_clock  (seg_clock),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .scan_tick  (scan_tick)
  );

  always #5 fast_clock = ~fast_clock;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        bl;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dark(input string name);
    chk({name, " an"}, 32'(an), 32'hF);
    chk({name, " seg"}, 32'(seg), 32'h7F);
    chk({name, " dp"}, 32'(dp), 32'h1);
  endtask

  // One seg_clock period of 8 fast cycles; called at a negedge with seg_clock low.
  task automatic step(input vec_t v, input string name);
    value      = v.value;
    dp_mask    = v.dp_mask;
    blank_lead = v.bl;
    seg_clock  = 1'b1;
    @(negedge fast_clock);
    chk({name, " tick early"}, 32'(scan_tick), 32'h0);
    @(negedge fast_clock);
    chk({name, " tick"}, 32'(scan_tick), 32'h1);
    @(negedge fast_clock);
    chk({name, " tick once"}, 32'(scan_tick), 32'h0);
    chk_dark({name, " guard1"});
    @(negedge fast_clock);
    chk({name, " guard2 an"}, 32'(an), 32'hF);
    seg_clock = 1'b0;
    @(negedge fast_clock);
    chk({name, " an"}, 32'(an), 32'(v.an));
    chk({name, " seg"}, 32'(seg), 32'(v.seg));
    chk({name, " dp"}, 32'(dp), 32'(v.dp));
    repeat (3) @(negedge fast_clock);
    chk({name, " hold an"}, 32'(an), 32'(v.an));
    chk({name, " hold seg"}, 32'(seg), 32'(v.seg));
    chk({name, " no fall tick"}, 32'(scan_tick), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h1234, 4'b0000, 1'b0, 4'hE, 7'h19, 1'b1};
    vecs[1]  = '{16'h1234, 4'b0000, 1'b0, 4'hD, 7'h30, 1'b1};
    vecs[2]  = '{16'hABCD, 4'b0000, 1'b0, 4'hB, 7'h24, 1'b1};
    vecs[3]  = '{16'hABCD, 4'b0000, 1'b0, 4'h7, 7'h79, 1'b1};
    vecs[4]  = '{16'hABCD, 4'b0000, 1'b0, 4'hE, 7'h21, 1'b1};
    vecs[5]  = '{16'hABCD, 4'b0000, 1'b0, 4'hD, 7'h46, 1'b1};
    vecs[6]  = '{16'hABCD, 4'b0000, 1'b0, 4'hB, 7'h03, 1'b1};
    vecs[7]  = '{16'h0050, 4'b0100, 1'b1, 4'h7, 7'h08, 1'b1};
    vecs[8]  = '{16'h0050, 4'b0100, 1'b1, 4'hE, 7'h40, 1'b1};
    vecs[9]  = '{16'h0050, 4'b0100, 1'b1, 4'hD, 7'h12, 1'b1};
    vecs[10] = '{16'h0050, 4'b0100, 1'b1, 4'hB, 7'h7F, 1'b0};
    vecs[11] = '{16'h0000, 4'b0000, 1'b1, 4'h7, 7'h7F, 1'b1};
    vecs[12] = '{16'h0000, 4'b0000, 1'b1, 4'hE, 7'h40, 1'b1};
    vecs[13] = '{16'h0000, 4'b0000, 1'b1, 4'hD, 7'h7F, 1'b1};
    vecs[14] = '{16'h0000, 4'b0000, 1'b1, 4'hB, 7'h7F, 1'b1};
    vecs[15] = '{16'hFE90, 4'b0000, 1'b0, 4'h7, 7'h7F, 1'b1};
    vecs[16] = '{16'hFE90, 4'b0000, 1'b0, 4'hE, 7'h40, 1'b1};
    vecs[17] = '{16'hFE90, 4'b0000, 1'b0, 4'hD, 7'h10, 1'b1};
    vecs[18] = '{16'hFE90, 4'b0000, 1'b0, 4'hB, 7'h06, 1'b1};
    vecs[19] = '{16'h8001, 4'b1001, 1'b1, 4'h7, 7'h0E, 1'b1};
    vecs[20] = '{16'h8001, 4'b1001, 1'b1, 4'hE, 7'h79, 1'b0};
    vecs[21] = '{16'h8001, 4'b1001, 1'b1, 4'hD, 7'h40, 1'b1};
    vecs[22] = '{16'h8001, 4'b1001, 1'b1, 4'hB, 7'h40, 1'b1};
    vecs[23] = '{16'h8001, 4'b1001, 1'b1, 4'h7, 7'h00, 1'b0};

    rst        = 1'b0;
    seg_clock  = 1'b0;
    value      = 16'h1234;
    dp_mask    = 4'b0000;
    blank_lead = 1'b0;

    // Reset held while seg_clock toggles: everything stays dark and idle.
    for (int c = 0; c < 10; c++) begin
      @(negedge fast_clock);
      seg_clock = ~seg_clock;
      chk_dark($sformatf("reset c%0d", c));
      chk($sformatf("reset c%0d tick", c), 32'(scan_tick), 32'h0);
    end
    seg_clock = 1'b0;
    repeat (3) @(negedge fast_clock);
    rst = 1'b1;
    repeat (2) @(negedge fast_clock);

    for (int i = 0; i < 24; i++) step(vecs[i], $sformatf("v%0d", i));

    // Ticks every 2 cycles keep the FSM in GUARD; index walks 3->0(reload)->1->2->3->0->1.
    value      = 16'h4321;
    dp_mask    = 4'b0000;
    blank_lead = 1'b0;
    seg_clock  = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge fast_clock);
      seg_clock = (c < 12) && (c % 2 == 0);
      if (c >= 3 && c <= 14) chk($sformatf("burst c%0d an", c), 32'(an), 32'hF);
    end
    chk("burst end an", 32'(an), 32'hD);
    chk("burst end seg", 32'(seg), 32'h24);
    chk("burst end dp", 32'(dp), 32'h1);
    repeat (2) @(negedge fast_clock);
    step('{16'h4321, 4'b0001, 1'b0, 4'hB, 7'h30, 1'b1}, "post burst");

    // Async reset while digit 2 is lit.
    chk("pre reset an", 32'(an), 32'hB);
    #2 rst = 1'b0;
    #1;
    chk_dark("async reset");
    repeat (3) @(negedge fast_clock);
    chk_dark("reset hold");
    rst = 1'b1;
    repeat (2) @(negedge fast_clock);
    chk_dark("after release");
    step('{16'h4321, 4'b0001, 1'b0, 4'hE, 7'h79, 1'b0}, "restart d0");
    step('{16'h4321, 4'b0001, 1'b0, 4'hD, 7'h24, 1'b1}, "restart d1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
